// File: rtl/otter_fetch_unit.sv
// otter_fetch_unit
//   Program-counter register and instruction-fetch sequencer for the OTTER
//   core. Holds the architectural PC, fetches from instruction memory over a
//   req/ack handshake and hands the instruction to decode over valid/ready.
//
//   Optional feature macro: PC_MISALIGN_CHECK_EN
//     defined   -> a PC load with next_pc[1:0] != 0 raises a sticky
//                  misalign_err and parks in TRAP until a redirect.
//     undefined -> misalign_err tied to 0, misaligned targets are fetched.
//
//   Ports
//     CLK, RST         clock, async active-high reset
//     next_pc          PC-source mux output, sampled on a PC load
//     redirect         trap/interrupt PC load, flushes fetch/ir
//     imem_req/addr    fetch request and address (addr == pc)
//     imem_ack/rdata   memory response
//     ir_valid/ready   decode handshake, ir is the instruction register
//     pc, pc_plus4     current PC and pc+4 (mod 2^32) for mux select 0
//     misalign_err     sticky misaligned-PC flag
//
//   state | meaning
//   IDLE  | out of reset, first fetch issued on next edge
//   FETCH | imem_req high, waiting for imem_ack
//   HOLD  | ir valid, waiting for decode to accept it
//   TRAP  | misaligned PC loaded, waiting for redirect (macro only)

module otter_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

`ifdef PC_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, TRAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif

  state_t state;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

`ifdef PC_MISALIGN_CHECK_EN
  logic misalign_q;
  logic target_misaligned;

  assign target_misaligned = (next_pc[1:0] != 2'b00);
  assign misalign_err      = misalign_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= 32'h0;
      ir_valid   <= 1'b0;
      imem_req   <= 1'b0;
      misalign_q <= 1'b0;
    end else if (redirect || (state == HOLD && ir_valid && ir_ready)) begin
      // PC load: redirect wins over ack/ready; any ack this cycle is dropped.
      pc       <= next_pc;
      ir_valid <= 1'b0;
      if (target_misaligned) begin
        state      <= TRAP;
        imem_req   <= 1'b0;
        misalign_q <= 1'b1;
      end else begin
        state      <= FETCH;
        imem_req   <= 1'b1;
        misalign_q <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: ;
        TRAP: ;
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end
`else
  assign misalign_err = 1'b0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= 32'h0;
      ir_valid <= 1'b0;
      imem_req <= 1'b0;
    end else if (redirect || (state == HOLD && ir_valid && ir_ready)) begin
      // PC load: redirect wins over ack/ready; any ack this cycle is dropped.
      pc       <= next_pc;
      ir_valid <= 1'b0;
      state    <= FETCH;
      imem_req <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: ;
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: doc/otter_fetch_unit.md
# otter_fetch_unit

Program-counter register and instruction-fetch sequencer for the OTTER core. It consumes the 32-bit next-PC value selected by the PC-source mux, holds it as the architectural PC, and issues fetch requests to instruction memory over a req/ack handshake. It presents the fetched instruction to decode over a valid/ready handshake, and drives `pc_plus4` back into select 0 of the PC-source mux.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `next_pc` in 32: next PC from the PC-source mux; sampled only on a PC load.
- `redirect` in 1: forces a PC load from `next_pc` and discards any fetched or in-flight instruction. Used for traps and interrupts.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ack` in 1: memory response valid; may assert in the same cycle as `imem_req`.
- `imem_rdata` in 32: instruction word; valid when `imem_ack`=1.
- `ir_valid` out 1: `ir` holds a valid instruction.
- `ir_ready` in 1: decode accepts `ir`.
- `ir` out 32: fetched instruction register.
- `pc` out 32: PC of the instruction in `ir` or being fetched.
- `pc_plus4` out 32: `pc + 4`, combinational, modulo 2^32.
- `misalign_err` out 1: sticky misaligned-PC flag (see Configuration).

## Operation
- States: IDLE, FETCH, HOLD, TRAP. TRAP is reachable only with the macro defined.
- IDLE: entered on reset. Moves to FETCH unconditionally on the first clock edge after `RST` deasserts. A `redirect` in IDLE loads `pc` and still moves to FETCH.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack`=1: `ir`<=`imem_rdata`, `ir_valid`<=1, go to HOLD.
  - Otherwise stay in FETCH with the address held stable.
- HOLD:
  - `imem_req`=0, `ir_valid`=1, `ir` stable.
  - On `ir_valid`&&`ir_ready`: `pc`<=`next_pc`, `ir_valid`<=0, go to FETCH.
- `redirect`=1 in FETCH or HOLD:
  - `pc`<=`next_pc`, `ir_valid`<=0, go to FETCH.
  - An `imem_ack` in the same cycle is dropped and `ir` is not updated.
  - `redirect` takes priority over `ir_ready` and over `imem_ack`.
- A PC load happens only on an `ir` handshake or on `redirect`. Otherwise `pc` holds.
- `next_pc` is stored as-is, with no masking.
- `pc_plus4` wraps: `pc`=32'hFFFF_FFFC gives `pc_plus4`=32'h0000_0000.

## Timing
- Reset values: `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4, `ir`=0, `ir_valid`=0, `imem_req`=0, `misalign_err`=0, state IDLE.
- Reset asserted mid-fetch or mid-hold returns everything to the reset values immediately (asynchronous). A pending ack is ignored.
- First `imem_req` is in cycle 1 after reset release.
- Zero-wait memory: ack in the same cycle as the request gives `ir_valid` in the next cycle. Minimum handshake-to-next-`ir_valid` is 2 cycles (FETCH, then HOLD).
- Back-to-back throughput: one instruction per 2 cycles.
- `imem_req`, `ir_valid`, and `misalign_err` are register-driven. `imem_addr` and `pc_plus4` derive only from the `pc` register. No combinational path runs from any input to any output.

## Configuration
- Macro: `PC_MISALIGN_CHECK_EN`.
- Defined:
  - A PC load with `next_pc[1:0]`!=0 still loads `pc`, sets `misalign_err`<=1, and enters TRAP.
  - TRAP: `imem_req`=0, `ir_valid`=0, `misalign_err` held at 1.
  - Only `redirect` leaves TRAP. It clears `misalign_err`, loads `pc`, and goes to FETCH. An aligned target is checked again.
- Undefined:
  - `misalign_err` is tied to 0 and there is no TRAP state.
  - A misaligned `next_pc` is fetched like any other address.

## Test plan
- Reset release with `RESET_PC`=32'h0000_0000 and zero-wait memory returning 32'h0000_0013: `imem_req` in cycle 1, `ir_valid`=1 with `ir`=32'h0000_0013 in cycle 2, `pc_plus4`=32'h4.
- Handshake with `next_pc`=32'h0000_0040 and memory ack delayed 3 cycles: `imem_addr`=32'h40 held stable for 3 cycles, then `ir_valid` in the cycle after the ack.
- `ir_ready`=0 for 5 cycles in HOLD: `ir`, `pc`, and `ir_valid` are unchanged and `imem_req`=0.
- `redirect` with `next_pc`=32'h0000_0100 in the same cycle as `imem_ack`: the data is dropped, `ir_valid` stays 0, and the next `imem_addr` is 32'h100.
- `pc`=32'hFFFF_FFFC gives `pc_plus4`=32'h0.
- With `PC_MISALIGN_CHECK_EN` defined, a handshake with `next_pc`=32'h0000_0102 gives `misalign_err`=1 and no `imem_req`. A later `redirect` to 32'h200 clears the flag and fetches 32'h200. With the macro undefined, the same stimulus fetches 32'h102 and `misalign_err` stays 0.
